// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// The master side presents operands and accepts results; the slave side
// is the controller itself.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is time-shared across all
// bit positions, LSB first, one bit per clock. Operands arrive on a
// valid/ready handshake and the result leaves on another; the result
// registers keep the last completed sum until the next one replaces it.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic              busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_nxt;
  logic             accept;
  logic             running;

  // The single shared full-adder cell: returns {carry-out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign {fa_cout, fa_sum} = full_add(a_sh[0], b_sh[0], carry);
  assign accept  = (state == IDLE) && bus.in_valid;
  assign running = (state == RUN);

  // Partial-sum shifter. Only the upper WIDTH-1 bits of the partial sum are
  // ever needed again, so that is all that is stored; the newest sum bit
  // enters at the top and the full result is formed combinationally.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_sum;
    end else begin : g_wn
      logic [WIDTH-2:0] sum_sh;

      assign sum_nxt = {fa_sum, sum_sh};

      // Clear on accept, shift one result bit in per RUN cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_sh <= '0;
        end else if (accept) begin
          sum_sh <= '0;
        end else if (running) begin
          sum_sh <= sum_nxt[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // Controller FSM with registered handshake outputs and operand shifters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      a_sh          <= '0;
      b_sh          <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh         <= bus.a;
            b_sh         <= bus.b;
            carry        <= bus.cin;
            cnt          <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state         <= HOLD;
            bus.sum       <= sum_nxt;
            bus.cout      <= fa_cout;
            bus.out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for latency,
// handshake, volatility and reset cases, and a 4-bit instance swept over
// every operand combination with random result stalls.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  logic busy8;
  logic busy4;
  int   n_checks;
  int   n_errors;

  serial_add_ctrl_if #(.WIDTH(8)) b8 ();
  serial_add_ctrl_if #(.WIDTH(4)) b4 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8),
    .busy  (busy8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4),
    .busy  (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one operand set to the 8-bit DUT for one edge, then scramble the
  // operand lines so any late sampling shows up in the result.
  task automatic accept8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    b8.a = ta;
    b8.b = tb_;
    b8.cin = tc;
    b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b8.a = 8'hFF;
    b8.b = 8'hFF;
    b8.cin = 1'b1;
  endtask

  // Full operation on the 8-bit DUT with out_ready held high.
  task automatic do_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic [7:0] es, input logic ec);
    int lat;
    int bcnt;
    lat = 0;
    b8.out_ready = 1'b1;
    while (!b8.in_ready && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_idle"}, b8.in_ready, 1'b1);
    accept8(ta, tb_, tc);
    bcnt = busy8 ? 1 : 0;
    lat = 0;
    while (!b8.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, b8.sum, es);
    chk({tag, "_cout"}, b8.cout, ec);
    @(posedge clk); #1;
    chk({tag, "_busycyc"}, bcnt, 9);
    chk({tag, "_ovdrop"}, b8.out_valid, 1'b0);
    chk({tag, "_rdy"}, b8.in_ready, 1'b1);
    chk({tag, "_busy0"}, busy8, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [4:0] e4;
    logic [3:0] ta4;
    logic [3:0] tb4;
    logic       tc4;
    int         stall;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", b8.in_ready, 1'b1);
    chk("rst_ov", b8.out_valid, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_sum", b8.sum, 8'h00);
    chk("rst_cout", b8.cout, 1'b0);
    chk("rst_rdy4", b4.in_ready, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operands, latency and busy duration
    do_op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Carry propagation patterns
    do_op8("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op8("a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_op8("7f80", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0);

    // Backpressure with an ignored in_valid pulse during HOLD
    b8.out_ready = 1'b0;
    accept8(8'h12, 8'h34, 1'b0);
    lat = 0;
    while (!b8.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 8);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        b8.a = 8'hFF;
        b8.b = 8'hFF;
        b8.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      chk("bp_ov", b8.out_valid, 1'b1);
      chk("bp_sum", b8.sum, 8'h46);
      chk("bp_cout", b8.cout, 1'b0);
      chk("bp_rdy", b8.in_ready, 1'b0);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ovdrop", b8.out_valid, 1'b0);
    chk("bp_rdy1", b8.in_ready, 1'b1);
    chk("bp_busy0", busy8, 1'b0);
    @(posedge clk); #1;
    chk("bp_noaccept", busy8, 1'b0);

    // Operand lines change during RUN (accept8 always scrambles them)
    do_op8("volat", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // Asynchronous reset three edges into RUN
    b8.out_ready = 1'b1;
    accept8(8'h55, 8'h33, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", b8.out_valid, 1'b0);
    chk("arst_busy", busy8, 1'b0);
    chk("arst_rdy", b8.in_ready, 1'b1);
    chk("arst_sum", b8.sum, 8'h00);
    chk("arst_cout", b8.cout, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_noresult", b8.out_valid, 1'b0);
    do_op8("post_rst", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Exhaustive 4-bit sweep with random stalls
    for (int i = 0; i < 512; i++) begin
      ta4 = i[3:0];
      tb4 = i[7:4];
      tc4 = i[8];
      e4 = {1'b0, ta4} + {1'b0, tb4} + {4'b0, tc4};
      b4.out_ready = 1'b0;
      lat = 0;
      while (!b4.in_ready && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      b4.a = ta4;
      b4.b = tb4;
      b4.cin = tc4;
      b4.in_valid = 1'b1;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      b4.a = ~ta4;
      b4.b = ~tb4;
      b4.cin = ~tc4;
      lat = 0;
      while (!b4.out_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("ex_lat", lat, 4);
      chk("ex_res", {b4.cout, b4.sum}, e4);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("ex_hold", {b4.out_valid, b4.cout, b4.sum}, {1'b1, e4});
      end
      b4.out_ready = 1'b1;
      @(posedge clk); #1;
      b4.out_ready = 1'b0;
      chk("ex_once", b4.out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
